// File: rtl/map_table_ckpt_pkg.sv
// Shared types for the R10K rename map table with branch checkpoints.
// PHYS_REG_SIZE_R10K sets the physical register count (64 when not given).
`ifndef PHYS_REG_SIZE_R10K
`define PHYS_REG_SIZE_R10K 64
`endif

package map_table_ckpt_pkg;

  localparam int unsigned N         = 2;
  localparam int unsigned ARCH_REGS = 32;
  localparam int unsigned PHYS_REGS = `PHYS_REG_SIZE_R10K;
  localparam int unsigned CDB_W     = N;
  localparam int unsigned NUM_CKPT  = 4;

  localparam int unsigned ARCH_W = $clog2(ARCH_REGS);
  localparam int unsigned PHYS_W = $clog2(PHYS_REGS);
  localparam int unsigned CKPT_W = $clog2(NUM_CKPT);

  typedef logic [ARCH_W-1:0] arch_reg_idx_t;
  typedef logic [PHYS_W-1:0] phys_reg_idx_t;
  typedef logic [CKPT_W-1:0] ckpt_idx_t;
  typedef logic [CKPT_W:0]   ckpt_cnt_t;
  typedef phys_reg_idx_t [ARCH_REGS-1:0] map_t;

  // Reset mapping: every architectural register maps to the preg of the same number.
  function automatic map_t identity_map();
    map_t m;
    for (int unsigned i = 0; i < ARCH_REGS; i++) m[i] = phys_reg_idx_t'(i);
    return m;
  endfunction

endpackage

// File: rtl/map_table_ckpt_if.sv
// Dispatch-side bundle of the rename map table: rename ports, CDB,
// checkpoint control and exception rollback.
interface map_table_ckpt_if;
  import map_table_ckpt_pkg::*;

  logic          [N-1:0]     rn_valid;
  logic          [N-1:0]     rn_dest_valid;
  arch_reg_idx_t [N-1:0]     rn_dest_idx;
  phys_reg_idx_t [N-1:0]     rn_new_preg;
  arch_reg_idx_t [2*N-1:0]   rn_src_idx;
  phys_reg_idx_t [2*N-1:0]   rn_src_preg;
  logic          [2*N-1:0]   rn_src_ready;
  phys_reg_idx_t [N-1:0]     rn_t_old;
  logic          [CDB_W-1:0] cdb_valid;
  phys_reg_idx_t [CDB_W-1:0] cdb_preg;
  logic                      ckpt_req;
  ckpt_idx_t                 ckpt_id;
  logic                      ckpt_full;
  logic                      ckpt_free;
  logic                      restore_valid;
  ckpt_idx_t                 restore_id;
  logic                      rollback_valid;
  map_t                      rollback_map;

  modport master (
    output rn_valid, rn_dest_valid, rn_dest_idx, rn_new_preg, rn_src_idx,
           cdb_valid, cdb_preg, ckpt_req, ckpt_free, restore_valid, restore_id,
           rollback_valid, rollback_map,
    input  rn_src_preg, rn_src_ready, rn_t_old, ckpt_id, ckpt_full
  );

  modport slave (
    input  rn_valid, rn_dest_valid, rn_dest_idx, rn_new_preg, rn_src_idx,
           cdb_valid, cdb_preg, ckpt_req, ckpt_free, restore_valid, restore_id,
           rollback_valid, rollback_map,
    output rn_src_preg, rn_src_ready, rn_t_old, ckpt_id, ckpt_full
  );

endinterface

// File: rtl/map_table_ckpt_ring.sv
// Checkpoint ring: snapshot storage with head (oldest), tail (next free)
// and occupancy count; supports write, free-oldest, restore and flush.
module map_ckpt_ring
  import map_table_ckpt_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  input  logic      flush,
  input  logic      wr_en,
  input  map_t      wr_map,
  input  logic      free_en,
  input  logic      restore_en,
  input  ckpt_idx_t restore_id,
  output map_t      rd_map,
  output ckpt_idx_t tail_id,
  output logic      full
);

  map_t      snap [NUM_CKPT];
  ckpt_idx_t head_q;
  ckpt_idx_t tail_q;
  ckpt_cnt_t count_q;
  logic      free_eff;
  logic      wr_eff;
  ckpt_idx_t head_adv;

  // A free retires the oldest entry before a same-cycle write is judged against full.
  assign full     = (count_q == ckpt_cnt_t'(NUM_CKPT));
  assign free_eff = free_en && (count_q != '0);
  assign head_adv = head_q + ckpt_idx_t'(free_eff);
  assign wr_eff   = wr_en && !flush && !restore_en && (!full || free_eff);
  assign rd_map   = snap[restore_id];
  assign tail_id  = tail_q;

  // Pointer/count update; a restore keeps the restored entry and drops everything younger.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (restore_en) begin
      head_q  <= head_adv;
      tail_q  <= restore_id + ckpt_idx_t'(1);
      count_q <= ckpt_cnt_t'(ckpt_idx_t'(restore_id - head_adv)) + ckpt_cnt_t'(1);
    end else begin
      head_q  <= head_adv;
      if (wr_eff) tail_q <= tail_q + ckpt_idx_t'(1);
      count_q <= count_q + ckpt_cnt_t'(wr_eff) - ckpt_cnt_t'(free_eff);
    end
  end

  // Snapshot storage, written at the tail slot.
  always_ff @(posedge clock) begin
    if (wr_eff) snap[tail_q] <= wr_map;
  end

endmodule

// File: rtl/map_table_ckpt.sv
// N-way rename map table with ready vector, CDB wakeup, intra-bundle
// forwarding and branch checkpoints. Define MAP_TABLE_CKPT_EN to build
// the checkpoint ring and restore path; otherwise recovery is rollback only.
module map_table_ckpt
  import map_table_ckpt_pkg::*;
(
  input  logic           clock,
  input  logic           reset,
  map_table_ckpt_if.slave bus
);

  map_t                   map_q;
  map_t                   map_post;
  map_t                   ckpt_rd_map;
  logic [PHYS_REGS-1:0]   ready_q;
  logic [PHYS_REGS-1:0]   ready_nxt;
  logic [N-1:0]           dest_we;
  logic                   restore_en;
  logic                   rename_en;
  logic [2*N-1:0]         src_fwd;
  phys_reg_idx_t [2*N-1:0] src_fwd_tag;
  logic [2*N-1:0]         src_cdb;
  logic [N-1:0]           old_fwd;
  phys_reg_idx_t [N-1:0]  old_fwd_tag;

  assign rename_en = !bus.rollback_valid && !restore_en;

  // Slots that really write a mapping (arch reg 0 is never remapped).
  always_comb begin
    dest_we = '0;
    for (int unsigned i = 0; i < N; i++)
      dest_we[i] = bus.rn_valid[i] && bus.rn_dest_valid[i] && (bus.rn_dest_idx[i] != '0);
  end

  // Intra-bundle forwarding: the youngest older slot writing the same arch reg supplies the tag.
  always_comb begin
    src_fwd     = '0;
    src_fwd_tag = '0;
    old_fwd     = '0;
    old_fwd_tag = '0;
    for (int unsigned j = 0; j < N; j++) begin
      for (int unsigned i = 0; i < j; i++) begin
        for (int unsigned s = 0; s < 2; s++) begin
          if (dest_we[i] && (bus.rn_dest_idx[i] == bus.rn_src_idx[2*j+s])) begin
            src_fwd[2*j+s]     = 1'b1;
            src_fwd_tag[2*j+s] = bus.rn_new_preg[i];
          end
        end
        if (dest_we[i] && (bus.rn_dest_idx[i] == bus.rn_dest_idx[j])) begin
          old_fwd[j]     = 1'b1;
          old_fwd_tag[j] = bus.rn_new_preg[i];
        end
      end
    end
  end

  // Same-cycle CDB wakeup of a mapped source.
  always_comb begin
    src_cdb = '0;
    for (int unsigned k = 0; k < 2*N; k++)
      for (int unsigned c = 0; c < CDB_W; c++)
        if (bus.cdb_valid[c] && (bus.cdb_preg[c] == map_q[bus.rn_src_idx[k]])) src_cdb[k] = 1'b1;
  end

  // Source tags/ready and T_old, combinational from state and this cycle's inputs.
  always_comb begin
    bus.rn_src_preg  = '0;
    bus.rn_src_ready = '0;
    bus.rn_t_old     = '0;
    for (int unsigned k = 0; k < 2*N; k++) begin
      if (bus.rn_src_idx[k] == '0) begin
        bus.rn_src_preg[k]  = '0;
        bus.rn_src_ready[k] = 1'b1;
      end else if (src_fwd[k]) begin
        bus.rn_src_preg[k]  = src_fwd_tag[k];
        bus.rn_src_ready[k] = 1'b0;
      end else begin
        bus.rn_src_preg[k]  = map_q[bus.rn_src_idx[k]];
        bus.rn_src_ready[k] = ready_q[map_q[bus.rn_src_idx[k]]] | src_cdb[k];
      end
    end
    for (int unsigned j = 0; j < N; j++) begin
      if (bus.rn_dest_idx[j] == '0)  bus.rn_t_old[j] = '0;
      else if (old_fwd[j])           bus.rn_t_old[j] = old_fwd_tag[j];
      else                           bus.rn_t_old[j] = map_q[bus.rn_dest_idx[j]];
    end
  end

  // Map after this cycle's renames; later slots overwrite earlier ones.
  always_comb begin
    map_post = map_q;
    for (int unsigned i = 0; i < N; i++)
      if (dest_we[i]) map_post[bus.rn_dest_idx[i]] = bus.rn_new_preg[i];
  end

  // Ready vector: CDB sets first, then allocation clears so a same-cycle allocation wins.
  always_comb begin
    ready_nxt = ready_q;
    for (int unsigned c = 0; c < CDB_W; c++)
      if (bus.cdb_valid[c]) ready_nxt[bus.cdb_preg[c]] = 1'b1;
    if (rename_en)
      for (int unsigned i = 0; i < N; i++)
        if (dest_we[i]) ready_nxt[bus.rn_new_preg[i]] = 1'b0;
  end

  // Map and ready state with rollback > restore > rename priority.
  always_ff @(posedge clock) begin
    if (reset) begin
      map_q   <= identity_map();
      ready_q <= '1;
    end else begin
      ready_q <= ready_nxt;
      if (bus.rollback_valid) map_q <= bus.rollback_map;
      else if (restore_en)    map_q <= ckpt_rd_map;
      else                    map_q <= map_post;
    end
  end

`ifdef MAP_TABLE_CKPT_EN
  assign restore_en = bus.restore_valid && !bus.rollback_valid;

  map_ckpt_ring u_ring (
    .clock      (clock),
    .reset      (reset),
    .flush      (bus.rollback_valid),
    .wr_en      (bus.ckpt_req && rename_en),
    .wr_map     (map_post),
    .free_en    (bus.ckpt_free && !bus.rollback_valid),
    .restore_en (restore_en),
    .restore_id (bus.restore_id),
    .rd_map     (ckpt_rd_map),
    .tail_id    (bus.ckpt_id),
    .full       (bus.ckpt_full)
  );

  // A checkpoint request while full is dropped; dispatch is expected to stall instead.
  cover property (@(posedge clock) disable iff (reset)
    bus.ckpt_req && bus.ckpt_full && !bus.ckpt_free && rename_en);
`else
  logic unused_ckpt;

  assign restore_en    = 1'b0;
  assign ckpt_rd_map   = map_q;
  assign bus.ckpt_id   = '0;
  assign bus.ckpt_full = 1'b1;
  assign unused_ckpt   = ^{bus.ckpt_req, bus.ckpt_free, bus.restore_valid, bus.restore_id};
`endif

endmodule

// File: tb/tb_map_table_ckpt.sv
// Scoreboard bench for map_table_ckpt: stimulus pushes expected outputs
// from a reference model; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_map_table_ckpt;
  import map_table_ckpt_pkg::*;

`ifdef MAP_TABLE_CKPT_EN
  localparam bit CKPT_EN = 1'b1;
`else
  localparam bit CKPT_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  map_table_ckpt_if bus();
  map_table_ckpt dut (.clock(clock), .reset(reset), .bus(bus));

  typedef struct { int sel; int idx; int exp; } exp_t;
  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  // Reference model: plain arrays plus a queue of live checkpoint ids (oldest first).
  int m_map   [ARCH_REGS];
  bit m_ready [PHYS_REGS];
  int ck_map  [NUM_CKPT][ARCH_REGS];
  int ck_ids[$];
  int m_tail;

  function automatic string sel_name(int s);
    case (s)
      0: return "src_preg";
      1: return "src_ready";
      2: return "t_old";
      3: return "ckpt_id";
      default: return "ckpt_full";
    endcase
  endfunction

  function automatic logic [31:0] actual(int s, int i);
    case (s)
      0: return 32'(bus.rn_src_preg[i]);
      1: return 32'(bus.rn_src_ready[i]);
      2: return 32'(bus.rn_t_old[i]);
      3: return 32'(bus.ckpt_id);
      default: return 32'(bus.ckpt_full);
    endcase
  endfunction

  task automatic push(int s, int i, int e);
    exp_t x;
    x.sel = s; x.idx = i; x.exp = e;
    sb.push_back(x);
  endtask

  // Monitor: outputs are combinational, so compare everything queued for this cycle at negedge.
  initial begin
    exp_t e;
    logic [31:0] a;
    forever begin
      @(negedge clock);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        a = actual(e.sel, e.idx);
        total++;
        if (a !== 32'(e.exp)) begin
          bad++;
          $display("FAIL %s[%0d] got=%0d want=%0d", sel_name(e.sel), e.idx, a, e.exp);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic clr();
    bus.rn_valid = '0; bus.rn_dest_valid = '0; bus.rn_dest_idx = '0;
    bus.rn_new_preg = '0; bus.rn_src_idx = '0; bus.cdb_valid = '0;
    bus.cdb_preg = '0; bus.ckpt_req = 1'b0; bus.ckpt_free = 1'b0;
    bus.restore_valid = 1'b0; bus.restore_id = '0; bus.rollback_valid = 1'b0;
    bus.rollback_map = '0;
  endtask

  function automatic bit writes(int i);
    return bus.rn_valid[i] && bus.rn_dest_valid[i] && (int'(bus.rn_dest_idx[i]) != 0);
  endfunction

  // Value of arch reg a as seen by slot `slot`, following the bundle rules.
  task automatic model_read(int a, int slot, output int p, output bit r);
    if (a == 0) begin p = 0; r = 1'b1; return; end
    p = m_map[a];
    r = m_ready[p];
    for (int c = 0; c < CDB_W; c++)
      if (bus.cdb_valid[c] && int'(bus.cdb_preg[c]) == p) r = 1'b1;
    for (int i = 0; i < slot; i++)
      if (writes(i) && int'(bus.rn_dest_idx[i]) == a) begin p = int'(bus.rn_new_preg[i]); r = 1'b0; end
  endtask

  task automatic model_expect();
    int p; bit r;
    for (int k = 0; k < 2*N; k++) begin
      model_read(int'(bus.rn_src_idx[k]), k / 2, p, r);
      push(0, k, p);
      push(1, k, int'(r));
    end
    for (int j = 0; j < N; j++) begin
      model_read(int'(bus.rn_dest_idx[j]), j, p, r);
      push(2, j, p);
    end
    push(3, 0, CKPT_EN ? m_tail : 0);
    push(4, 0, CKPT_EN ? int'(ck_ids.size() == NUM_CKPT) : 1);
  endtask

  task automatic model_update();
    int rid;
    for (int c = 0; c < CDB_W; c++)
      if (bus.cdb_valid[c]) m_ready[int'(bus.cdb_preg[c])] = 1'b1;
    if (bus.rollback_valid) begin
      for (int a = 0; a < ARCH_REGS; a++) m_map[a] = int'(bus.rollback_map[a]);
      ck_ids.delete();
      m_tail = 0;
    end else if (CKPT_EN && bus.restore_valid) begin
      rid = int'(bus.restore_id);
      if (bus.ckpt_free && ck_ids.size() > 0) void'(ck_ids.pop_front());
      while (ck_ids.size() > 0 && ck_ids[$] != rid) void'(ck_ids.pop_back());
      for (int a = 0; a < ARCH_REGS; a++) m_map[a] = ck_map[rid][a];
      m_tail = (rid + 1) % NUM_CKPT;
    end else begin
      for (int i = 0; i < N; i++)
        if (writes(i)) begin
          m_map[int'(bus.rn_dest_idx[i])] = int'(bus.rn_new_preg[i]);
          m_ready[int'(bus.rn_new_preg[i])] = 1'b0;
        end
      if (CKPT_EN) begin
        if (bus.ckpt_free && ck_ids.size() > 0) void'(ck_ids.pop_front());
        if (bus.ckpt_req && ck_ids.size() < NUM_CKPT) begin
          for (int a = 0; a < ARCH_REGS; a++) ck_map[m_tail][a] = m_map[a];
          ck_ids.push_back(m_tail);
          m_tail = (m_tail + 1) % NUM_CKPT;
        end
      end
    end
  endtask

  task automatic cycle();
    model_expect();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic ren(int slot, int dest, int preg);
    bus.rn_valid[slot] = 1'b1;
    bus.rn_dest_valid[slot] = 1'b1;
    bus.rn_dest_idx[slot] = arch_reg_idx_t'(dest);
    bus.rn_new_preg[slot] = phys_reg_idx_t'(preg);
  endtask

  initial begin
    int n, pick;
    reset = 1'b1;
    clr();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    for (int a = 0; a < ARCH_REGS; a++) m_map[a] = a;
    for (int p = 0; p < PHYS_REGS; p++) m_ready[p] = 1'b1;
    ck_ids.delete();
    m_tail = 0;

    // Reset state reads.
    clr();
    bus.rn_src_idx[0] = 5'd1; bus.rn_src_idx[1] = 5'd2; bus.rn_dest_idx[0] = 5'd4;
    push(0, 0, 1); push(0, 1, 2); push(1, 0, 1); push(1, 1, 1); push(2, 0, 4);
    push(3, 0, 0); push(4, 0, CKPT_EN ? 0 : 1);
    #1;
    total++;
    if (bus.rn_src_preg[1] !== phys_reg_idx_t'(2)) begin
      bad++;
      $display("FAIL direct reset src_preg[1] got=%0d want=2", bus.rn_src_preg[1]);
    end
    cycle();

    // Bundle dependency: slot0 r3->p40, slot1 reads r3 and writes r3->p41.
    clr();
    ren(0, 3, 40); ren(1, 3, 41);
    bus.rn_src_idx[2] = 5'd3;
    push(0, 2, 40); push(1, 2, 0); push(2, 1, 40); push(0, 3, 0); push(1, 3, 1);
    #1;
    total++;
    if (bus.rn_t_old[1] !== phys_reg_idx_t'(40)) begin
      bad++;
      $display("FAIL direct bundle t_old[1] got=%0d want=40", bus.rn_t_old[1]);
    end
    total++;
    if (bus.rn_src_ready[2] !== 1'b0) begin
      bad++;
      $display("FAIL direct bundle src_ready[2] got=%0d want=0", bus.rn_src_ready[2]);
    end
    cycle();
    clr();
    bus.rn_src_idx[0] = 5'd3;
    push(0, 0, 41); push(1, 0, 0);
    cycle();

    // Wakeup: r5->p50, then same-cycle and registered CDB.
    clr(); ren(0, 5, 50); cycle();
    clr(); bus.rn_src_idx[0] = 5'd5; push(1, 0, 0); cycle();
    clr(); bus.rn_src_idx[0] = 5'd5; bus.cdb_valid[0] = 1'b1; bus.cdb_preg[0] = 6'd50;
    push(0, 0, 50); push(1, 0, 1); cycle();
    clr(); bus.rn_src_idx[1] = 5'd5; push(1, 1, 1); cycle();

    // Checkpoint and restore; the rename in the restore cycle must be dropped.
    clr(); ren(0, 7, 60); bus.ckpt_req = 1'b1; push(3, 0, 0); cycle();
    clr(); ren(0, 7, 61); cycle();
    clr(); ren(0, 7, 62); bus.restore_valid = 1'b1; bus.restore_id = '0; cycle();
    clr(); bus.rn_src_idx[0] = 5'd7;
    push(0, 0, CKPT_EN ? 60 : 62); push(3, 0, CKPT_EN ? 1 : 0);
    #1;
    total++;
    if (bus.rn_src_preg[0] !== phys_reg_idx_t'(CKPT_EN ? 60 : 62)) begin
      bad++;
      $display("FAIL direct restore src_preg[0] got=%0d", bus.rn_src_preg[0]);
    end
    cycle();

    // Fill the ring, overflow request, free, and free+request when full.
    for (int i = 0; i < 3; i++) begin clr(); bus.ckpt_req = 1'b1; cycle(); end
    clr(); bus.ckpt_req = 1'b1; push(4, 0, 1); push(3, 0, 0); cycle();
    clr(); bus.ckpt_free = 1'b1; push(4, 0, 1); push(3, 0, 0); cycle();
    clr(); bus.ckpt_req = 1'b1; push(4, 0, CKPT_EN ? 0 : 1); cycle();
    clr(); bus.ckpt_req = 1'b1; bus.ckpt_free = 1'b1; push(4, 0, 1); push(3, 0, CKPT_EN ? 1 : 0); cycle();
    clr(); push(4, 0, 1); push(3, 0, CKPT_EN ? 2 : 0); cycle();

    // Rollback beats restore, rename and ckpt_req.
    clr();
    bus.rollback_valid = 1'b1;
    for (int a = 0; a < ARCH_REGS; a++) bus.rollback_map[a] = phys_reg_idx_t'(a + 32);
    bus.restore_valid = 1'b1; bus.restore_id = 2'd1; bus.ckpt_req = 1'b1; ren(0, 9, 5);
    cycle();
    clr();
    bus.rn_src_idx[0] = 5'd1;
    #1;
    total++;
    if (bus.rn_src_preg[0] !== phys_reg_idx_t'(33)) begin
      bad++;
      $display("FAIL direct rollback src_preg[0] got=%0d want=33", bus.rn_src_preg[0]);
    end
    for (int r = 0; r < ARCH_REGS / 4; r++) begin
      clr();
      for (int k = 0; k < 4; k++) begin
        bus.rn_src_idx[k] = arch_reg_idx_t'(4*r + k);
        push(0, k, (4*r + k == 0) ? 0 : 4*r + k + 32);
      end
      if (r == 0) begin push(4, 0, CKPT_EN ? 0 : 1); push(3, 0, 0); end
      cycle();
    end

    // Randomized traffic against the model.
    for (int t = 0; t < 400; t++) begin
      clr();
      for (int i = 0; i < N; i++) begin
        bus.rn_valid[i] = 1'($urandom_range(0, 3) != 0);
        bus.rn_dest_valid[i] = 1'($urandom_range(0, 3) != 0);
        bus.rn_dest_idx[i] = arch_reg_idx_t'($urandom_range(0, 7));
        bus.rn_new_preg[i] = phys_reg_idx_t'($urandom_range(1, PHYS_REGS - 1));
      end
      for (int k = 0; k < 2*N; k++) bus.rn_src_idx[k] = arch_reg_idx_t'($urandom_range(0, 7));
      for (int c = 0; c < CDB_W; c++) begin
        bus.cdb_valid[c] = 1'($urandom_range(0, 1));
        bus.cdb_preg[c] = phys_reg_idx_t'($urandom_range(0, PHYS_REGS - 1));
      end
      bus.ckpt_req = 1'($urandom_range(0, 9) < 3);
      bus.ckpt_free = 1'($urandom_range(0, 9) < 2);
      n = ck_ids.size();
      if (n > 0 && $urandom_range(0, 9) == 0) begin
        if (bus.ckpt_free && n == 1) bus.ckpt_free = 1'b0;
        pick = bus.ckpt_free ? $urandom_range(1, n - 1) : $urandom_range(0, n - 1);
        bus.restore_valid = 1'b1;
        bus.restore_id = ckpt_idx_t'(ck_ids[pick]);
      end
      if ($urandom_range(0, 49) == 0) begin
        bus.rollback_valid = 1'b1;
        for (int a = 0; a < ARCH_REGS; a++)
          bus.rollback_map[a] = phys_reg_idx_t'($urandom_range(1, PHYS_REGS - 1));
      end
      cycle();
    end

    clr();
    @(negedge clock);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/map_table_ckpt.md
# map_table_ckpt

N-way R10K rename map table with a per-physical-register ready vector, CDB wakeup, intra-bundle dependency forwarding and branch checkpoints for single-cycle mispredict recovery. Sits in dispatch between the free list and the RS/ROB: it translates 2N architectural sources and N destinations per cycle and returns T_old for the ROB. Exceptions recover by bulk-loading the retirement (architectural) map.

## Interface
- N, 2, rename width (instructions per cycle)
- ARCH_REGS, 32, architectural registers; index 0 is hardwired zero
- PHYS_REGS, `PHYS_REG_SIZE_R10K, physical registers
- CDB_W, N, CDB broadcast ports
- NUM_CKPT, 4, branch checkpoints (power of two)

- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- rn_valid  in  N  slot i carries a renamed instruction
- rn_dest_valid  in  N  slot i writes a destination
- rn_dest_idx  in  N x ARCH_REG_IDX  destination arch reg
- rn_new_preg  in  N x PHYS_REG_IDX  preg from free list
- rn_src_idx  in  2N x ARCH_REG_IDX  sources; slot i uses [2i], [2i+1]
- rn_src_preg  out  2N x PHYS_REG_IDX  source tags
- rn_src_ready  out  2N  source value available
- rn_t_old  out  N x PHYS_REG_IDX  previous mapping of the destination
- cdb_valid  in  CDB_W  broadcast valid
- cdb_preg  in  CDB_W x PHYS_REG_IDX  completing tag
- ckpt_req  in  1  snapshot the map after this cycle's renames
- ckpt_id  out  CKPT_IDX  id the next ckpt_req receives
- ckpt_full  out  1  no free checkpoint
- ckpt_free  in  1  release the oldest checkpoint (branch retired)
- restore_valid  in  1  mispredict
- restore_id  in  CKPT_IDX  checkpoint to restore
- rollback_valid  in  1  exception recovery
- rollback_map  in  ARCH_REGS x PHYS_REG_IDX  architectural map

## Operation
- State: map[ARCH_REGS], ready[PHYS_REGS], checkpoint ring (head = oldest, tail = next free, count).
- Reads are combinational from current state. Slot j's source or T_old whose arch index matches the destination of an older valid slot i<j in the same bundle takes the youngest such rn_new_preg, with ready 0.
- Non-forwarded sources: ready = ready[preg] OR a same-cycle cdb match.
- Arch index 0: source reads return preg 0, ready 1; destination writes to 0 are ignored, and T_old is 0.
- Rename write: map[dest] <= rn_new_preg; ready[rn_new_preg] <= 0. Among slots writing the same dest, the youngest wins.
- CDB: ready[cdb_preg] <= 1. If the same preg is allocated in the same cycle, the allocation clear wins.
- ckpt_req with !ckpt_full: ckpt[tail] <= post-rename map; tail++, count++.
- ckpt_req with ckpt_full: ignored. Dispatch must stall; this is covered by an assertion.
- ckpt_free: head++, count--. It is ignored when count==0.
- restore_valid: map <= ckpt[restore_id]; tail <= restore_id+1; count = distance(head, tail). The restored checkpoint is kept because the branch is still in flight. Younger checkpoints are discarded. Renames and ckpt_req in that cycle are ignored. ckpt_free in the same cycle is applied.
- rollback_valid: map <= rollback_map; all checkpoints discarded; renames, ckpt_req, restore and ckpt_free ignored; the ready vector is unchanged apart from CDB.
- Priority: reset > rollback > restore > rename/ckpt_req. CDB always applies.
- Ready bits are not checkpointed. Squashed pregs return to the free list and are cleared again on reallocation.

## Timing
- Read outputs: 0 cycles, combinational on inputs and state.
- Writes, checkpoints, restore and rollback become visible the next cycle.
- Reset values: map[i]=i, ready all 1, head=tail=count=0, ckpt_id=0, ckpt_full=0.
- Other outputs are combinational functions of this reset state.
- Ring pointers wrap modulo NUM_CKPT; ckpt_full = (count==NUM_CKPT).
- ckpt_req and ckpt_free in the same cycle when full: the free takes effect first, so the request is accepted.

## Configuration
- MAP_TABLE_CKPT_EN defined: checkpoint ring and restore path are built as described.
- MAP_TABLE_CKPT_EN undefined: no snapshot storage; ckpt_full=1 and ckpt_id=0 constantly; ckpt_req, ckpt_free and restore are ignored. Recovery is by rollback only.

## Structure
- Shared package holds ARCH_REG_IDX, PHYS_REG_IDX, CKPT_IDX typedefs and MAP_T (ARCH_REGS x PHYS_REG_IDX).
- One sub-module, map_ckpt_ring: snapshot storage plus head/tail/count, with write, free, restore-read and truncate.

## Test plan
- Reset, then read srcs 1,2 -> preg 1,2, ready 1, T_old=dest index.
- Bundle: slot0 r3->p40, slot1 src r3 and dest r3->p41.
  - Required: slot1 src p40 ready 0; slot1 T_old p40; next cycle map[3]=p41.
- Rename r5->p50; two cycles later cdb p50 -> read r5 gives p50 with ready 1.
  - A cdb on p50 in the same cycle as a read also yields ready 1.
- ckpt_req with r7->p60 (id 0); then r7->p61; restore_id 0 -> map[7]=p60, ckpt_id=1.
- Fill NUM_CKPT checkpoints -> ckpt_full=1; an extra ckpt_req changes nothing.
  - ckpt_free -> ckpt_full=0, head advances.
- rollback_valid with map[i]=i+32 asserted together with restore and rename -> map equals rollback_map and all checkpoints are cleared.
